ram_dat_line_seq: RTL and testbench
===================================

Name: ram_dat_line_seq

Overview:
- Initiator side of the per-way data RAM command/response interface (cmd_en/cmd_wen/cmd_addr/cmd_wdata -> resp_rdata).
- Sequences whole-line operations on one way of one set:
  - FILL: writes a line streamed in from the memory-side refill path.
  - EVICT: reads a line out and streams it to the writeback path under valid/ready backpressure.
- Sits between the cache control FSM and the data RAM array.

Parameters:
WAYS_N, 4, number of ways; width of one-hot way vectors
SET_W, 6, set index width
OFF_W, 2, word-within-line index width; words per line = 2**OFF_W
DAT_W, 32, RAM word width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_vld  in  1  line operation request valid
req_rdy  out  1  request accepted when req_vld & req_rdy
req_op  in  1  0 = FILL, 1 = EVICT
req_way  in  WAYS_N  one-hot target way
req_set  in  SET_W  target set
fill_vld  in  1  fill word valid
fill_rdy  out  1  fill word accepted
fill_dat  in  DAT_W  fill word, word 0 first
evict_vld  out  1  evicted word valid
evict_rdy  in  1  evicted word consumed
evict_dat  out  DAT_W  evicted word, word 0 first
evict_last  out  1  marks word 2**OFF_W-1
done  out  1  one-cycle pulse when operation completes
cmd_en  out  WAYS_N  RAM enable per way
cmd_wen  out  WAYS_N  RAM write enable per way
cmd_addr  out  SET_W+OFF_W  {set, word index}
cmd_wdata  out  DAT_W  RAM write data
resp_rdata  in  WAYS_N*DAT_W  per-way read data; way g at [g*DAT_W +: DAT_W]; valid one cycle after read enable

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE; counters = 0; skid buffer empty; in-flight flag = 0.
  - req_rdy = 1.
  - Outputs fill_rdy, evict_vld, evict_last, done, cmd_en, cmd_wen = 0.
  - evict_dat and cmd_wdata are don't-care, driven 0.
- Reset mid-operation: abort immediately; any in-flight RAM read is discarded; no done pulse.
- States: IDLE, FILL, EVICT.
- IDLE:
  - req_rdy = 1.
  - On handshake: latch way/set, clear counters; go to FILL or EVICT per req_op.
  - req_rdy = 0 in all other states.
- req_way must be one-hot. Non-one-hot is an assertion failure with no defined behaviour.
- FILL:
  - fill_rdy = 1, combinational on state.
  - Each fill handshake, same cycle, drives:
    - cmd_en = cmd_wen = latched way
    - cmd_addr = {set, wr_cnt}
    - cmd_wdata = fill_dat
  - wr_cnt then increments.
  - No handshake -> cmd_en = 0.
  - After the word with wr_cnt = 2**OFF_W-1: next state IDLE, with done = 1 in that next cycle (req_rdy also 1).
- EVICT:
  - 2-entry skid FIFO of {data, last}.
  - A read issues in a cycle when rd_cnt has not exhausted AND (occupancy + inflight − pop) < 2, where pop = evict_vld & evict_rdy.
  - Read drives cmd_en = way, cmd_wen = 0, cmd_addr = {set, rd_cnt}; rd_cnt then increments.
  - Next cycle: the selected way's resp_rdata slice is pushed into the FIFO; last = (index == 2**OFF_W-1).
  - evict_vld = FIFO non-empty; evict_dat/evict_last = FIFO head, all registered.
  - Outputs hold stable while evict_vld & !evict_rdy.
  - Simultaneous push and pop is legal at any occupancy satisfying the issue rule. The FIFO never overflows.
  - After popping the last word: next state IDLE, done = 1 that cycle.
- Latency:
  - Request handshake at cycle 0 -> first RAM command at cycle 1.
  - EVICT with evict_rdy held 1: evict_vld at cycles 3..3+2**OFF_W-1, one word per cycle, done at following cycle.
  - FILL with fill_vld held 1: writes at cycles 1..2**OFF_W, done at 2**OFF_W+1.
- Counters are OFF_W bits. Completion is tracked with a separate exhausted flag, so wrap to 0 never re-issues.

Test Plan:
- FILL way 4'b0100, set 5, fill_vld=1, data A0..A3 -> writes at cycles 1..4, cmd_addr 0x14..0x17, cmd_wen=4'b0100; done cycle 5; req_rdy=0 cycles 1..4.
- FILL with fill_vld low on cycles 2 and 3 -> cmd_en=0 those cycles; still 4 writes in order; done after 4th write.
- EVICT way 4'b0001, set 5, evict_rdy=1, RAM preloaded B0..B3 -> evict_dat B0..B3 at cycles 3..6; evict_last only at cycle 6; done cycle 7.
- EVICT with evict_rdy=0 for cycles 2..8 -> at most 2 reads issued before stall; FIFO holds B0,B1; no further cmd_en until pop; all 4 words delivered in order after release.
- rst asserted mid-EVICT, after 2 words popped -> next cycle all outputs 0, req_rdy=1; new FILL request proceeds normally.
- req_vld held during EVICT -> req_rdy=0 until done cycle; second request accepted on done cycle.

Source files
------------

// File: rtl/ram_dat_line_seq_if.sv
// Request, fill, evict and data-RAM command/response signals of the line sequencer.
// The master modport is the sequencer side; the slave modport is the surrounding environment.
interface ram_dat_line_seq_if #(
    parameter int WAYS_N = 4,
    parameter int SET_W  = 6,
    parameter int OFF_W  = 2,
    parameter int DAT_W  = 32
);
    logic                     req_vld;
    logic                     req_rdy;
    logic                     req_op;
    logic [WAYS_N-1:0]        req_way;
    logic [SET_W-1:0]         req_set;
    logic                     fill_vld;
    logic                     fill_rdy;
    logic [DAT_W-1:0]         fill_dat;
    logic                     evict_vld;
    logic                     evict_rdy;
    logic [DAT_W-1:0]         evict_dat;
    logic                     evict_last;
    logic                     done;
    logic [WAYS_N-1:0]        cmd_en;
    logic [WAYS_N-1:0]        cmd_wen;
    logic [SET_W+OFF_W-1:0]   cmd_addr;
    logic [DAT_W-1:0]         cmd_wdata;
    logic [WAYS_N*DAT_W-1:0]  resp_rdata;

    modport master (
        input  req_vld, req_op, req_way, req_set, fill_vld, fill_dat, evict_rdy, resp_rdata,
        output req_rdy, fill_rdy, evict_vld, evict_dat, evict_last, done,
               cmd_en, cmd_wen, cmd_addr, cmd_wdata
    );

    modport slave (
        output req_vld, req_op, req_way, req_set, fill_vld, fill_dat, evict_rdy, resp_rdata,
        input  req_rdy, fill_rdy, evict_vld, evict_dat, evict_last, done,
               cmd_en, cmd_wen, cmd_addr, cmd_wdata
    );
endinterface

// File: rtl/ram_dat_line_seq.sv
// Line sequencer for the per-way data RAM: FILL streams a refill line into one way/set,
// EVICT reads a line out through a 2-entry skid FIFO under writeback backpressure.
module ram_dat_line_seq #(
    parameter int WAYS_N = 4,
    parameter int SET_W  = 6,
    parameter int OFF_W  = 2,
    parameter int DAT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    ram_dat_line_seq_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EVICT} state_t;
    localparam logic [OFF_W-1:0] LAST_IDX = '1;

    state_t            state, state_nxt;
    logic              done_q;
    logic [WAYS_N-1:0] way_q;
    logic [SET_W-1:0]  set_q;
    logic [OFF_W-1:0]  wr_cnt, rd_cnt;
    logic              rd_exh;
    logic              rd_vld_p1, rd_last_p1;
    logic [DAT_W-1:0]  rd_dat_p1;
    logic [1:0]        occ;
    logic [DAT_W-1:0]  fifo_dat [2];
    logic              fifo_last [2];
    logic              req_hs, fill_hs, pop, push, issue;
    logic [2:0]        slots_used;

    always_comb begin
        req_hs     = (state == S_IDLE) && bus.req_vld;
        fill_hs    = (state == S_FILL) && bus.fill_vld;
        pop        = (occ != 2'd0) && bus.evict_rdy;
        push       = rd_vld_p1;
        // A read may only issue if its word is guaranteed a FIFO slot when it returns.
        slots_used = {1'b0, occ} + {2'b0, rd_vld_p1} - {2'b0, pop};
        issue      = (state == S_EVICT) && !rd_exh && (slots_used < 3'd2);
    end

    always_comb begin
        rd_dat_p1 = '0;
        for (int g = 0; g < WAYS_N; g++) begin
            if (way_q[g]) rd_dat_p1 = rd_dat_p1 | bus.resp_rdata[g*DAT_W +: DAT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state != S_IDLE) && (state_nxt == S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_hs) state_nxt = bus.req_op ? S_EVICT : S_FILL;
            S_FILL:  if (fill_hs && (wr_cnt == LAST_IDX)) state_nxt = S_IDLE;
            S_EVICT: if (pop && fifo_last[0]) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy    = (state == S_IDLE);
        bus.fill_rdy   = (state == S_FILL);
        bus.done       = done_q;
        bus.cmd_en     = '0;
        bus.cmd_wen    = '0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.evict_vld  = (occ != 2'd0);
        bus.evict_dat  = (occ != 2'd0) ? fifo_dat[0] : '0;
        bus.evict_last = (occ != 2'd0) && fifo_last[0];
        if (fill_hs) begin
            bus.cmd_en    = way_q;
            bus.cmd_wen   = way_q;
            bus.cmd_addr  = {set_q, wr_cnt};
            bus.cmd_wdata = bus.fill_dat;
        end else if (issue) begin
            bus.cmd_en   = way_q;
            bus.cmd_addr = {set_q, rd_cnt};
        end
    end

    // p0 -> p1: read issued this cycle, response data arrives next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rd_exh    <= 1'b0;
            rd_vld_p1 <= 1'b0;
            occ       <= 2'd0;
        end else begin
            if (req_hs) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
                rd_exh <= 1'b0;
            end
            if (fill_hs) wr_cnt <= wr_cnt + 1'b1;
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LAST_IDX) rd_exh <= 1'b1;
            end
            rd_vld_p1 <= issue;
            occ       <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // p1 -> FIFO: response word enters the skid buffer behind any held entry
    always_ff @(posedge clk) begin
        if (req_hs) begin
            way_q <= bus.req_way;
            set_q <= bus.req_set;
        end
        if (issue) rd_last_p1 <= (rd_cnt == LAST_IDX);
        if (push && pop) begin
            if (occ == 2'd2) begin
                fifo_dat[0]  <= fifo_dat[1];
                fifo_last[0] <= fifo_last[1];
                fifo_dat[1]  <= rd_dat_p1;
                fifo_last[1] <= rd_last_p1;
            end else begin
                fifo_dat[0]  <= rd_dat_p1;
                fifo_last[0] <= rd_last_p1;
            end
        end else if (pop) begin
            fifo_dat[0]  <= fifo_dat[1];
            fifo_last[0] <= fifo_last[1];
        end else if (push) begin
            if (occ == 2'd0) begin
                fifo_dat[0]  <= rd_dat_p1;
                fifo_last[0] <= rd_last_p1;
            end else begin
                fifo_dat[1]  <= rd_dat_p1;
                fifo_last[1] <= rd_last_p1;
            end
        end
    end

    a_req_way_onehot: assert property (@(posedge clk) disable iff (rst)
        (bus.req_vld && bus.req_rdy) |-> $onehot(bus.req_way));
endmodule

// File: tb/tb_ram_dat_line_seq.sv
// Directed bench for ram_dat_line_seq with a behavioural per-way data RAM.
module tb_ram_dat_line_seq;
    localparam int WAYS_N = 4;
    localparam int SET_W  = 6;
    localparam int OFF_W  = 2;
    localparam int DAT_W  = 32;
    localparam int AW     = SET_W + OFF_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_dat_line_seq_if #(.WAYS_N(WAYS_N), .SET_W(SET_W), .OFF_W(OFF_W), .DAT_W(DAT_W)) bus ();
    ram_dat_line_seq #(.WAYS_N(WAYS_N), .SET_W(SET_W), .OFF_W(OFF_W), .DAT_W(DAT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    logic [DAT_W-1:0]        mem [WAYS_N][2**AW];
    logic [WAYS_N*DAT_W-1:0] rdata_q;
    logic                    pl_en;
    logic [1:0]              pl_way;
    logic [AW-1:0]           pl_addr;
    logic [DAT_W-1:0]        pl_dat;
    assign bus.resp_rdata = rdata_q;

    always @(posedge clk) begin
        if (pl_en) mem[pl_way][pl_addr] <= pl_dat;
        for (int g = 0; g < WAYS_N; g++) begin
            if (bus.cmd_en[g]) begin
                if (bus.cmd_wen[g]) mem[g][bus.cmd_addr] <= bus.cmd_wdata;
                else rdata_q[g*DAT_W +: DAT_W] <= mem[g][bus.cmd_addr];
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int w, input int set, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            pl_en = 1'b1; pl_way = 2'(w); pl_addr = AW'(set * 4 + i); pl_dat = base + 32'(i);
            tick();
        end
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pl_en = 1'b0; pl_way = '0; pl_addr = '0; pl_dat = '0;
        bus.req_vld = 0; bus.req_op = 0; bus.req_way = '0; bus.req_set = '0;
        bus.fill_vld = 0; bus.fill_dat = '0; bus.evict_rdy = 0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.req_rdy, bus.fill_rdy, bus.evict_vld, bus.evict_last, bus.done} !== 5'b10000) begin
            n_err++; $display("FAIL reset_ctrl got %b want 10000",
                {bus.req_rdy, bus.fill_rdy, bus.evict_vld, bus.evict_last, bus.done});
        end
        n_vec++;
        if ({bus.cmd_en, bus.cmd_wen} !== 8'h00) begin
            n_err++; $display("FAIL reset_cmd got %h want 00", {bus.cmd_en, bus.cmd_wen});
        end
        n_vec++;
        if ({bus.evict_dat, bus.cmd_wdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_data got %h want 0", {bus.evict_dat, bus.cmd_wdata});
        end
    endtask

    // Observed: {cmd_en, cmd_wen, cmd_addr, cmd_wdata, req_rdy, fill_rdy, done}
    task automatic test_fill();
        logic [50:0] obs, exp;
        bus.req_vld = 1; bus.req_op = 0; bus.req_way = 4'b0100; bus.req_set = 6'd5;
        @(negedge clk);
        n_vec++;
        if (bus.req_rdy !== 1'b1) begin n_err++; $display("FAIL fill_req_rdy got %b want 1", bus.req_rdy); end
        tick();
        bus.req_vld = 0;
        for (int c = 1; c <= 6; c++) begin
            bus.fill_vld = (c <= 4);
            bus.fill_dat = 32'hA0A0_0000 + 32'(c - 1);
            @(negedge clk);
            if (c <= 4) exp = {4'b0100, 4'b0100, 8'(8'h13 + c), 32'hA0A0_0000 + 32'(c - 1), 3'b010};
            else if (c == 5) exp = {8'h00, 8'h00, 32'h0, 3'b101};
            else exp = {8'h00, 8'h00, 32'h0, 3'b100};
            obs = {bus.cmd_en, bus.cmd_wen, (c <= 4) ? bus.cmd_addr : 8'h0,
                   (c <= 4) ? bus.cmd_wdata : 32'h0, bus.req_rdy, bus.fill_rdy, bus.done};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL fill c%0d got %h want %h", c, obs, exp); end
            tick();
        end
        bus.fill_vld = 0;
    endtask

    task automatic test_fill_gaps();
        logic [50:0] obs, exp;
        logic [7:0]  t_vld  = 8'b0111_0010;
        logic [7:0]  t_done = 8'b1000_0000;
        logic [7:0]  t_addr [8] = '{8'h00, 8'h24, 8'h00, 8'h00, 8'h25, 8'h26, 8'h27, 8'h00};
        logic [31:0] t_wd   [8] = '{32'h0, 32'hC0C0_0000, 32'h0, 32'h0,
                                    32'hC0C0_0001, 32'hC0C0_0002, 32'hC0C0_0003, 32'h0};
        int k = 0;
        bus.req_vld = 1; bus.req_op = 0; bus.req_way = 4'b0010; bus.req_set = 6'd9;
        @(negedge clk);
        n_vec++;
        if (bus.req_rdy !== 1'b1) begin n_err++; $display("FAIL gaps_req_rdy got %b want 1", bus.req_rdy); end
        tick();
        bus.req_vld = 0;
        for (int c = 1; c <= 7; c++) begin
            bus.fill_vld = t_vld[c];
            bus.fill_dat = t_vld[c] ? 32'hC0C0_0000 + 32'(k) : 32'hDEAD_BEEF;
            if (t_vld[c]) k++;
            @(negedge clk);
            exp = {t_vld[c] ? 4'b0010 : 4'b0000, t_vld[c] ? 4'b0010 : 4'b0000, t_addr[c], t_wd[c],
                   t_done[c], !t_done[c], t_done[c]};
            obs = {bus.cmd_en, bus.cmd_wen, t_vld[c] ? bus.cmd_addr : 8'h0,
                   t_vld[c] ? bus.cmd_wdata : 32'h0, bus.req_rdy, bus.fill_rdy, bus.done};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL gaps c%0d got %h want %h", c, obs, exp); end
            tick();
        end
        bus.fill_vld = 0;
    endtask

    // Observed: {cmd_en, cmd_wen, cmd_addr, evict_vld, evict_dat, evict_last, done}
    task automatic test_evict();
        logic [50:0] obs, exp;
        logic [7:0]  t_en   = 8'b0001_1110;
        logic [7:0]  t_vld  = 8'b0111_1000;
        logic [7:0]  t_last = 8'b0100_0000;
        logic [7:0]  t_done = 8'b1000_0000;
        logic [7:0]  t_addr [8] = '{8'h00, 8'h14, 8'h15, 8'h16, 8'h17, 8'h00, 8'h00, 8'h00};
        logic [31:0] t_dat  [8] = '{32'h0, 32'h0, 32'h0, 32'hB0B0_0000, 32'hB0B0_0001,
                                    32'hB0B0_0002, 32'hB0B0_0003, 32'h0};
        bus.req_vld = 1; bus.req_op = 1; bus.req_way = 4'b0001; bus.req_set = 6'd5; bus.evict_rdy = 1;
        @(negedge clk);
        n_vec++;
        if (bus.req_rdy !== 1'b1) begin n_err++; $display("FAIL evict_req_rdy got %b want 1", bus.req_rdy); end
        tick();
        bus.req_vld = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            exp = {t_en[c] ? 4'b0001 : 4'b0000, 4'b0000, t_addr[c], t_vld[c], t_dat[c], t_last[c], t_done[c]};
            obs = {bus.cmd_en, bus.cmd_wen, t_en[c] ? bus.cmd_addr : 8'h0, bus.evict_vld,
                   t_vld[c] ? bus.evict_dat : 32'h0, bus.evict_last, bus.done};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL evict c%0d got %h want %h", c, obs, exp); end
            tick();
        end
        bus.evict_rdy = 0;
    endtask

    task automatic test_evict_stall();
        logic [50:0] obs, exp;
        logic [13:0] t_en   = 14'b00_0110_0000_0110;
        logic [13:0] t_vld  = 14'b01_1111_1111_1000;
        logic [13:0] t_last = 14'b01_0000_0000_0000;
        logic [13:0] t_done = 14'b10_0000_0000_0000;
        logic [13:0] t_rdy  = 14'b11_1110_0000_0010;
        logic [7:0]  t_addr [14] = '{8'h00, 8'h14, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00,
                                     8'h00, 8'h00, 8'h16, 8'h17, 8'h00, 8'h00, 8'h00};
        logic [31:0] t_dat  [14] = '{32'h0, 32'h0, 32'h0, 32'hD0D0_0000, 32'hD0D0_0000,
                                     32'hD0D0_0000, 32'hD0D0_0000, 32'hD0D0_0000, 32'hD0D0_0000,
                                     32'hD0D0_0000, 32'hD0D0_0001, 32'hD0D0_0002, 32'hD0D0_0003, 32'h0};
        bus.req_vld = 1; bus.req_op = 1; bus.req_way = 4'b1000; bus.req_set = 6'd5;
        @(negedge clk);
        n_vec++;
        if (bus.req_rdy !== 1'b1) begin n_err++; $display("FAIL stall_req_rdy got %b want 1", bus.req_rdy); end
        tick();
        bus.req_vld = 0;
        for (int c = 1; c <= 13; c++) begin
            bus.evict_rdy = t_rdy[c];
            @(negedge clk);
            exp = {t_en[c] ? 4'b1000 : 4'b0000, 4'b0000, t_addr[c], t_vld[c], t_dat[c], t_last[c], t_done[c]};
            obs = {bus.cmd_en, bus.cmd_wen, t_en[c] ? bus.cmd_addr : 8'h0, bus.evict_vld,
                   t_vld[c] ? bus.evict_dat : 32'h0, bus.evict_last, bus.done};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL stall c%0d got %h want %h", c, obs, exp); end
            tick();
        end
        bus.evict_rdy = 0;
    endtask

    task automatic test_reset_mid_evict();
        logic [50:0] obs, exp;
        bus.req_vld = 1; bus.req_op = 1; bus.req_way = 4'b0100; bus.req_set = 6'd5; bus.evict_rdy = 1;
        tick();
        bus.req_vld = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) rst = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({bus.evict_vld, (c >= 3) ? bus.evict_dat : 32'h0} !==
                {(c >= 3), (c >= 3) ? 32'hA0A0_0000 + 32'(c - 3) : 32'h0}) begin
                n_err++; $display("FAIL rstmid c%0d got %b/%h want word %0d", c, bus.evict_vld, bus.evict_dat, c - 3);
            end
            tick();
        end
        rst = 1'b0;
        for (int c = 6; c <= 7; c++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.req_rdy, bus.fill_rdy, bus.evict_vld, bus.evict_last, bus.done, bus.cmd_en, bus.cmd_wen}
                !== {5'b10000, 8'h00}) begin
                n_err++; $display("FAIL rstmid_idle c%0d got %b want 1000000000000", c,
                    {bus.req_rdy, bus.fill_rdy, bus.evict_vld, bus.evict_last, bus.done, bus.cmd_en, bus.cmd_wen});
            end
            tick();
        end
        bus.evict_rdy = 0;
        bus.req_vld = 1; bus.req_op = 0; bus.req_way = 4'b0001; bus.req_set = 6'd2;
        tick();
        bus.req_vld = 0;
        for (int c = 1; c <= 5; c++) begin
            bus.fill_vld = (c <= 4);
            bus.fill_dat = 32'hE0E0_0000 + 32'(c - 1);
            @(negedge clk);
            exp = (c <= 4) ? {4'b0001, 4'b0001, 8'(8'h07 + c), 32'hE0E0_0000 + 32'(c - 1), 3'b010}
                           : {8'h00, 8'h00, 32'h0, 3'b101};
            obs = {bus.cmd_en, bus.cmd_wen, (c <= 4) ? bus.cmd_addr : 8'h0,
                   (c <= 4) ? bus.cmd_wdata : 32'h0, bus.req_rdy, bus.fill_rdy, bus.done};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL rstmid_fill c%0d got %h want %h", c, obs, exp); end
            tick();
        end
        bus.fill_vld = 0;
    endtask

    task automatic test_back_to_back();
        logic [50:0] obs, exp;
        bus.req_vld = 1; bus.req_op = 1; bus.req_way = 4'b0001; bus.req_set = 6'd5; bus.evict_rdy = 1;
        tick();
        bus.req_op = 0; bus.req_way = 4'b0010; bus.req_set = 6'd7;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.req_rdy, bus.done, bus.evict_vld, (c >= 3 && c <= 6) ? bus.evict_dat : 32'h0} !==
                {(c == 7), (c == 7), (c >= 3 && c <= 6), (c >= 3 && c <= 6) ? 32'hB0B0_0000 + 32'(c - 3) : 32'h0}) begin
                n_err++; $display("FAIL b2b_evict c%0d got %b%b%b/%h", c, bus.req_rdy, bus.done, bus.evict_vld, bus.evict_dat);
            end
            tick();
        end
        bus.req_vld = 0; bus.evict_rdy = 0;
        for (int c = 1; c <= 5; c++) begin
            bus.fill_vld = (c <= 4);
            bus.fill_dat = 32'hF0F0_0000 + 32'(c - 1);
            @(negedge clk);
            exp = (c <= 4) ? {4'b0010, 4'b0010, 8'(8'h1B + c), 32'hF0F0_0000 + 32'(c - 1), 3'b010}
                           : {8'h00, 8'h00, 32'h0, 3'b101};
            obs = {bus.cmd_en, bus.cmd_wen, (c <= 4) ? bus.cmd_addr : 8'h0,
                   (c <= 4) ? bus.cmd_wdata : 32'h0, bus.req_rdy, bus.fill_rdy, bus.done};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL b2b_fill c%0d got %h want %h", c, obs, exp); end
            tick();
        end
        bus.fill_vld = 0;
    endtask

    initial begin
        test_reset();
        preload(0, 5, 32'hB0B0_0000);
        preload(1, 5, 32'h1111_0000);
        preload(3, 5, 32'hD0D0_0000);
        test_fill();
        test_fill_gaps();
        test_evict();
        test_evict_stall();
        test_reset_mid_evict();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
